// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine between the RV32I datapath and a valid/ready data bus.
// Handles lane alignment, byte enables, load extension, misalignment detection and bus timeouts.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        trnc_type,
  input  logic [2:0]        rdext_type,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic [1:0]        err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_BUS,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        trnc_q;
  logic [2:0]        rdext_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              misaligned;
  logic              timeout_hit;
  logic [1:0]        size;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_ext;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Alignment/legality check on the latched request
  always_comb begin
    misaligned = 1'b0;
    if (we_q) begin
      case (trnc_q)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = addr_q[0];
        2'b10:   misaligned = (addr_q[1:0] != 2'b00);
        default: misaligned = 1'b1;
      endcase
    end else begin
      case (rdext_q)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = addr_q[0];
        3'b010:         misaligned = (addr_q[1:0] != 2'b00);
        default:        misaligned = 1'b1;
      endcase
    end
  end

  // Lane placement: loads use the low two funct3 bits as their access size
  always_comb begin
    size = we_q ? trnc_q : rdext_q[1:0];
    case (size)
      2'b00:   be_calc = 4'b0001 << addr_q[1:0];
      2'b01:   be_calc = 4'b0011 << addr_q[1:0];
      default: be_calc = 4'b1111;
    endcase
    wdata_calc = 32'h0;
    if (we_q) begin
      case (trnc_q)
        2'b00:   wdata_calc = {4{wdata_q[7:0]}};
        2'b01:   wdata_calc = {2{wdata_q[15:0]}};
        default: wdata_calc = wdata_q;
      endcase
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   sel_byte = bus_rdata[7:0];
      2'b01:   sel_byte = bus_rdata[15:8];
      2'b10:   sel_byte = bus_rdata[23:16];
      default: sel_byte = bus_rdata[31:24];
    endcase
    sel_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (rdext_q)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'h0, sel_byte};
      3'b101:  load_ext = {16'h0, sel_half};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = req;
        if (req) state_d = S_CHECK;
      end
      S_CHECK: begin
        stall   = 1'b1;
        state_d = misaligned ? S_RESP : S_BUS;
      end
      S_BUS: begin
        stall = 1'b1;
        if (bus_ready || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, bus drive, response capture and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      trnc_q    <= 2'b00;
      rdext_q   <= 3'b000;
      cnt_q     <= '0;
      rdata     <= 32'h0;
      err       <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            trnc_q  <= trnc_type;
            rdext_q <= rdext_type;
          end
        end
        S_CHECK: begin
          if (misaligned) begin
            err <= 2'b01;
          end else begin
            err       <= 2'b00;
            bus_req   <= 1'b1;
            bus_we    <= we_q;
            bus_addr  <= {addr_q[ADDR_W-1:2], 2'b00};
            bus_be    <= be_calc;
            bus_wdata <= wdata_calc;
            cnt_q     <= '0;
          end
        end
        S_BUS: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            err     <= 2'b00;
            if (!we_q) rdata <= load_ext;
          end else if (timeout_hit) begin
            bus_req <= 1'b0;
            err     <= 2'b10;
            rdata   <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          err <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule
